// File: rtl/proc_exec_ctrl_pkg.sv
// Shared definitions for the unicycle execution controller: FSM state codes and
// the default number of cycles the core is held in reset.
package proc_exec_ctrl_pkg;

    typedef enum logic [2:0] {
        st_init  = 3'd0,
        st_halt  = 3'd1,
        st_step  = 3'd2,
        st_run   = 3'd3,
        st_break = 3'd4
    } state_t;

    localparam int unsigned INIT_CYCLES_DEF = 4;

endpackage

// File: rtl/proc_exec_ctrl_sync_edge.sv
// Multi-flop synchroniser for an asynchronous switch, with a one-cycle pulse on
// each rising edge of the synchronised level.
module proc_exec_ctrl_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level_d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= '0;
            level_d_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], din};
            level_d_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    // Both terms are flop outputs, so the pulse is glitch-free and one cycle wide.
    assign rise  = level & ~level_d_q;

endmodule

// File: rtl/proc_exec_ctrl.sv
// Execution controller for the unicycle core: gates the core clock-enable for
// reset-hold, halt, single-step, free-run and PC-breakpoint modes, and counts cycles.
module proc_exec_ctrl
    import proc_exec_ctrl_pkg::*;
#(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_sw,
    input  logic             step_sw,
    input  logic             halt_sw,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    input  logic             halt_instr,
    output logic             cpu_en,
    output logic             cpu_rst_n,
    output logic [2:0]       state,
    output logic             bp_hit,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

    state_t           state_q, state_d;
    logic [IW-1:0]    init_cnt_q, init_cnt_d;
    logic             cpu_rst_n_q;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cycle_cnt_q;

    logic run_s, halt_s, step_s, step_pulse;
    logic run_rise, halt_rise;
    logic unused_rise;
    logic bp_match, init_last;

    proc_exec_ctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_run (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (run_sw),
        .level (run_s),
        .rise  (run_rise)
    );

    proc_exec_ctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_step (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (step_sw),
        .level (step_s),
        .rise  (step_pulse)
    );

    proc_exec_ctrl_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_halt (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (halt_sw),
        .level (halt_s),
        .rise  (halt_rise)
    );

    // Edge outputs of the level-only switches and the step level are not needed.
    assign unused_rise = run_rise | halt_rise | step_s;

    assign bp_match  = bp_en & (pc == bp_addr);
    assign init_last = (init_cnt_q == IW'(INIT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        done_d     = done_q;
        cpu_en     = 1'b0;
        bp_hit     = 1'b0;
        case (state_q)
            st_halt: begin
                if (halt_s || done_q) begin
                    state_d = st_halt;
                end else if (step_pulse) begin
                    state_d = st_step;
                end else if (run_s) begin
                    state_d = st_run;
                end
            end
            st_step: begin
                // Breakpoint deliberately ignored so the core can step off it.
                cpu_en  = ~halt_instr;
                done_d  = done_q | halt_instr;
                state_d = st_halt;
            end
            st_run: begin
                cpu_en = ~halt_instr & ~bp_match & run_s & ~halt_s;
                if (halt_instr) begin
                    done_d  = 1'b1;
                    state_d = st_halt;
                end else if (bp_match) begin
                    state_d = st_break;
                end else if (halt_s || !run_s) begin
                    state_d = st_halt;
                end
            end
            st_break: begin
                bp_hit = 1'b1;
                if (step_pulse && !halt_s) begin
                    state_d = st_step;
                end else if (halt_s || !run_s) begin
                    state_d = st_halt;
                end
            end
            default: begin
                // Covers st_init and the unused encodings.
                if (init_last) begin
                    init_cnt_d = '0;
                    state_d    = st_halt;
                end else begin
                    init_cnt_d = init_cnt_q + 1'b1;
                    state_d    = st_init;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= st_init;
            init_cnt_q  <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cpu_rst_n_q <= (state_d != st_init);
            done_q      <= done_d;
            if (cpu_en && (cycle_cnt_q != {CNT_W{1'b1}})) begin
                cycle_cnt_q <= cycle_cnt_q + 1'b1;
            end
        end
    end

    assign state     = state_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign done      = done_q;
    assign cycle_cnt = cycle_cnt_q;

endmodule

// File: doc/proc_exec_ctrl.md
Name: proc_exec_ctrl

Overview:
- Execution controller for the unicycle processor; sits between the board switches and the Procesador core.
- Gates the core clock-enable to give reset-hold, halt, single-step, free-run and PC-breakpoint modes, and counts executed cycles.
- Switch inputs are asynchronous and synchronised internally; pc and halt_instr come from the core in the clk domain.

Parameters:
- PC_W, 8, width of program counter and breakpoint address.
- CNT_W, 16, width of executed-cycle counter.
- SYNC_STAGES, 2, flops in each switch synchroniser (min 2).
- INIT_CYCLES, 4, cycles cpu_rst_n is held low after reset release.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run_sw  in  1  async switch: level, 1 = run.
- step_sw  in  1  async switch: rising edge = one step.
- halt_sw  in  1  async switch: level, 1 = force halt.
- bp_en  in  1  breakpoint enable (clk domain).
- bp_addr  in  PC_W  breakpoint PC.
- pc  in  PC_W  current core PC.
- halt_instr  in  1  core decodes HALT at current pc.
- cpu_en  out  1  core clock-enable (combinational from state and inputs).
- cpu_rst_n  out  1  core reset, registered.
- state  out  3  FSM state code.
- bp_hit  out  1  high while in BREAK.
- done  out  1  sticky: HALT instruction reached.
- cycle_cnt  out  CNT_W  cycles with cpu_en=1, saturating.

Behaviour:
- Reset: async assert forces state=INIT, cpu_rst_n=0, done=0, cycle_cnt=0, synchronisers cleared, cpu_en=0, bp_hit=0, including mid-RUN/STEP.
- Synchronisers: run_s, step_s, halt_s = SYNC_STAGES-flop versions; step_pulse = step_s & ~step_s_d (one cycle).
- bp_match = bp_en & (pc == bp_addr).
- State codes: INIT=0, HALT=1, STEP=2, RUN=3, BREAK=4; others unreachable, decode as INIT.
- INIT: counter counts INIT_CYCLES cycles, then cpu_rst_n<=1, ->HALT.
- HALT: cpu_en=0. Priority: halt_s stays; done stays; step_pulse ->STEP; run_s ->RUN.
- STEP: cpu_en = ~halt_instr for exactly one cycle; ->HALT next. If halt_instr, set done. Breakpoint ignored in STEP (allows stepping off a breakpoint).
- RUN: cpu_en = ~halt_instr & ~bp_match & run_s & ~halt_s. Exit priority in same cycle: halt_instr -> set done, ->HALT; else bp_match ->BREAK; else halt_s or ~run_s ->HALT. Exit cycle never executes an instruction.
- BREAK: cpu_en=0, bp_hit=1. step_pulse (with ~halt_s) ->STEP; ~run_s or halt_s ->HALT; run_s alone holds BREAK.
- done=1 blocks STEP/RUN entry from HALT until reset.
- cycle_cnt increments whenever cpu_en=1; saturates at 2^CNT_W-1, no wrap.
- Latency: switch change to state change = SYNC_STAGES+1 cycles.

Decomposition:
- Shared header proc_ctrl_defs.vh: state code localparams, reset-hold default.
- One sub-module: sync_edge (SYNC_STAGES-flop synchroniser with registered rising-edge pulse output), instantiated for run_sw, step_sw, halt_sw.

Test Plan:
- Reset release, switches low -> cpu_rst_n low 4 cycles then high; state=1, cpu_en=0, cycle_cnt=0.
- step_sw 0->1 held 20 cycles -> exactly one cpu_en=1 cycle, cycle_cnt=1, state returns to 1; second rising edge -> cycle_cnt=2.
- run_sw=1, bp_en=1, bp_addr=8'h05, pc incrementing from 0 -> cpu_en high for pc 0..4, drops at pc=5, state=4, bp_hit=1, cycle_cnt=5; step_sw edge -> one cycle executes, pc=6, state=1.
- RUN with halt_instr asserted at pc=8'h0A -> cpu_en=0 that cycle, done=1, state=1; subsequent run_sw/step_sw edges -> no cpu_en until reset.
- CNT_W=4, run 20 cycles -> cycle_cnt saturates at 15.
- rst_n pulsed low mid-RUN (non-clock-aligned) -> immediate state=0, cpu_rst_n=0, cycle_cnt=0, done=0; INIT sequence repeats.
